// File: rtl/vcve2_csr_rmw_ctrl.sv
// Read-modify-write sequencer for a single CSR storage primitive.
// Accepts READ/WRITE/SET/CLEAR requests and reads the old value. It then
// writes the merged new value with a one-cycle strobe, optionally reads it
// back to confirm the write, and returns the old value plus an error flag.
module vcve2_csr_rmw_ctrl #(
  parameter int unsigned       Width       = 32,
  parameter bit                VerifyWrite = 1'b1,
  parameter logic [Width-1:0]  WriteMask   = {Width{1'b1}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [Width-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_error_o,
  output logic             csr_wr_en_o,
  output logic [Width-1:0] csr_wr_data_o,
  input  logic [Width-1:0] csr_rd_data_i,
  input  logic             csr_rd_error_i,
  output logic             busy_o
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    VERIFY,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [Width-1:0]   wdata_q, wdata_d;
  logic [Width-1:0]   old_q, old_d;
  logic [Width-1:0]   new_q, new_d;
  logic               err_q, err_d;
  logic               rsp_valid_q;
  logic               wr_en_q;
  logic               busy_q;

  logic [Width-1:0]   raw_val;
  logic [Width-1:0]   merged_val;
  logic               skip_write;

  // Compute the candidate new value from the live CSR read data and the
  // captured operand; only writable bits may change.
  always_comb begin
    raw_val = csr_rd_data_i;
    unique case (op_q)
      OP_WRITE: raw_val = wdata_q;
      OP_SET:   raw_val = csr_rd_data_i | wdata_q;
      OP_CLEAR: raw_val = csr_rd_data_i & ~wdata_q;
      default:  raw_val = csr_rd_data_i;
    endcase
    merged_val = (csr_rd_data_i & ~WriteMask) | (raw_val & WriteMask);
    // Reads, corrupted state and zero-operand set/clear never touch the CSR.
    skip_write = (op_q == OP_READ) | csr_rd_error_i |
                 (((op_q == OP_SET) | (op_q == OP_CLEAR)) & (wdata_q == '0));
  end

  // Next-state logic and datapath capture enables.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    new_d   = new_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          wdata_d = req_wdata_i;
          state_d = READ;
        end
      end
      READ: begin
        old_d   = csr_rd_data_i;
        err_d   = csr_rd_error_i;
        new_d   = merged_val;
        state_d = skip_write ? RESP : WRITE;
      end
      WRITE: begin
        state_d = VerifyWrite ? VERIFY : RESP;
      end
      VERIFY: begin
        err_d   = (csr_rd_data_i != new_q) | csr_rd_error_i;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      wdata_q     <= '0;
      old_q       <= '0;
      new_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      old_q       <= old_d;
      new_q       <= new_d;
      err_q       <= err_d;
      rsp_valid_q <= (state_d == RESP);
      wr_en_q     <= (state_d == WRITE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = old_q;
  assign rsp_error_o   = err_q;
  assign csr_wr_en_o   = wr_en_q;
  assign csr_wr_data_o = new_q;
  assign busy_o        = busy_q;

  a_req_valid_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(req_valid_i));
  a_rsp_ready_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(rsp_ready_i));
  a_wr_en_in_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
    csr_wr_en_o |-> (state_q == WRITE));
  a_rsp_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o && !rsp_ready_i) |=> rsp_valid_o);

endmodule

// File: tb/tb_vcve2_csr_rmw_ctrl.sv
// Bench for vcve2_csr_rmw_ctrl: two instances (default parameters, and a
// half-width write mask without readback) each driving a behavioural CSR.
module tb_vcve2_csr_rmw_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_op    [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_error [2];
  logic        wr_en     [2];
  logic [31:0] wr_data   [2];
  logic [31:0] rd_data   [2];
  logic        rd_err    [2];
  logic        busy      [2];
  logic [31:0] flip      [2];
  logic        ld        [2];
  logic [31:0] ld_val    [2];

  logic [31:0] csr0, csr1;

  int n_cmp = 0;
  int n_fail = 0;

  vcve2_csr_rmw_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_op_i(req_op[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_error_o(rsp_error[0]),
    .csr_wr_en_o(wr_en[0]), .csr_wr_data_o(wr_data[0]),
    .csr_rd_data_i(rd_data[0]), .csr_rd_error_i(rd_err[0]),
    .busy_o(busy[0])
  );

  vcve2_csr_rmw_ctrl #(
    .Width(32), .VerifyWrite(1'b0), .WriteMask(32'h0000_FFFF)
  ) dut_m (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_op_i(req_op[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_error_o(rsp_error[1]),
    .csr_wr_en_o(wr_en[1]), .csr_wr_data_o(wr_data[1]),
    .csr_rd_data_i(rd_data[1]), .csr_rd_error_i(rd_err[1]),
    .busy_o(busy[1])
  );

  // Behavioural CSR storage: preload port plus the DUT write strobe.
  always @(posedge clk) begin
    if (ld[0]) csr0 <= ld_val[0];
    else if (wr_en[0]) csr0 <= wr_data[0];
  end
  always @(posedge clk) begin
    if (ld[1]) csr1 <= ld_val[1];
    else if (wr_en[1]) csr1 <= wr_data[1];
  end
  assign rd_data[0] = csr0 ^ flip[0];
  assign rd_data[1] = csr1 ^ flip[1];

  function automatic logic [31:0] csr_of(input int sel);
    return (sel != 0) ? csr1 : csr0;
  endfunction

  // Reference: the new CSR value and whether a write happens at all.
  function automatic void model(input int sel, input logic [1:0] op, input logic [31:0] wd,
                                input logic [31:0] old, input bit rderr,
                                output logic [31:0] nv, output bit wr);
    logic [31:0] raw, m;
    m = (sel != 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    case (op)
      2'd1: raw = wd;
      2'd2: raw = old | wd;
      2'd3: raw = old & ~wd;
      default: raw = old;
    endcase
    nv = (old & ~m) | (raw & m);
    wr = !(op == 2'd0 || rderr || (op != 2'd1 && wd == 32'd0));
  endfunction

  task automatic load_csr(input int sel, input logic [31:0] v);
    ld[sel] = 1'b1;
    ld_val[sel] = v;
    @(negedge clk);
    ld[sel] = 1'b0;
  endtask

  // One complete transaction; starts and ends at a falling edge.
  task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] wd,
                        input bit rderr, input bit vmis, input int hold);
    logic [31:0] old, nv, exp_final, got_data, s_rdata;
    bit wr, exp_err, s_err;
    int exp_lat, lat, wcnt, wcyc;
    old = csr_of(sel);
    model(sel, op, wd, old, rderr, nv, wr);
    exp_lat = !wr ? 2 : ((sel == 0) ? 4 : 3);
    exp_err = rderr || (vmis && wr && sel == 0);
    exp_final = wr ? nv : old;
    n_cmp++;
    if (req_ready[sel] !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_idle[%0d]: got %b want 1", sel, req_ready[sel]);
    end
    req_valid[sel] = 1'b1; req_op[sel] = op; req_wdata[sel] = wd; rd_err[sel] = rderr;
    @(negedge clk);
    req_valid[sel] = 1'b0; req_op[sel] = $urandom_range(0, 3); req_wdata[sel] = $urandom;
    lat = 0; wcnt = 0; wcyc = 0; got_data = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      if (wr_en[sel]) begin wcnt++; wcyc = k; got_data = wr_data[sel]; end
      if (rsp_valid[sel]) begin lat = k; break; end
      if (k == 3 && vmis) flip[sel] = 32'h0000_0100;
      else flip[sel] = 32'd0;
      @(negedge clk);
    end
    flip[sel] = 32'd0; rd_err[sel] = 1'b0;
    n_cmp++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL latency[%0d] op=%0d: got %0d want %0d", sel, op, lat, exp_lat);
    end
    n_cmp++;
    if (wcnt != (wr ? 1 : 0)) begin
      n_fail++; $display("FAIL wr_pulses[%0d] op=%0d: got %0d want %0d", sel, op, wcnt, wr ? 1 : 0);
    end
    if (wr) begin
      n_cmp++;
      if (got_data !== nv || wcyc != 2) begin
        n_fail++; $display("FAIL wr_data[%0d]: got %h@%0d want %h@2", sel, got_data, wcyc, nv);
      end
    end
    n_cmp++;
    if (rsp_rdata[sel] !== old) begin
      n_fail++; $display("FAIL rsp_rdata[%0d]: got %h want %h", sel, rsp_rdata[sel], old);
    end
    n_cmp++;
    if (rsp_error[sel] !== exp_err) begin
      n_fail++; $display("FAIL rsp_error[%0d]: got %b want %b", sel, rsp_error[sel], exp_err);
    end
    s_rdata = rsp_rdata[sel]; s_err = rsp_error[sel];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid[sel] !== 1'b1 || rsp_rdata[sel] !== s_rdata || rsp_error[sel] !== s_err ||
          req_ready[sel] !== 1'b0) begin
        n_fail++;
        $display("FAIL rsp_hold[%0d] cyc %0d: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                 sel, h, rsp_valid[sel], rsp_rdata[sel], rsp_error[sel], req_ready[sel], s_rdata, s_err);
      end
    end
    rsp_ready[sel] = 1'b1;
    @(negedge clk);
    rsp_ready[sel] = 1'b0;
    n_cmp++;
    if (rsp_valid[sel] !== 1'b0 || req_ready[sel] !== 1'b1) begin
      n_fail++; $display("FAIL after_hs[%0d]: got v=%b rdy=%b want v=0 rdy=1", sel, rsp_valid[sel], req_ready[sel]);
    end
    n_cmp++;
    if (csr_of(sel) !== exp_final) begin
      n_fail++; $display("FAIL csr_value[%0d]: got %h want %h", sel, csr_of(sel), exp_final);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (rsp_valid[s] !== 1'b0 || rsp_rdata[s] !== 32'd0 || rsp_error[s] !== 1'b0 ||
          wr_en[s] !== 1'b0 || wr_data[s] !== 32'd0 || busy[s] !== 1'b0 || req_ready[s] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got v=%b d=%h e=%b we=%b wd=%h busy=%b rdy=%b want 0,0,0,0,0,0,1",
                 s, rsp_valid[s], rsp_rdata[s], rsp_error[s], wr_en[s], wr_data[s], busy[s], req_ready[s]);
      end
    end
  endtask

  task automatic test_read();
    load_csr(0, 32'h0000_00A5);
    run_op(0, 2'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
  endtask

  task automatic test_write_verify();
    load_csr(0, 32'h0000_00A5);
    run_op(0, 2'd1, 32'h1234_5678, 1'b0, 1'b0, 1);
    n_cmp++;
    if (csr0 !== 32'h1234_5678) begin
      n_fail++; $display("FAIL write_result: got %h want 12345678", csr0);
    end
  endtask

  task automatic test_set_clear();
    load_csr(0, 32'h0000_00F0);
    run_op(0, 2'd2, 32'h0000_000F, 1'b0, 1'b0, 0);
    run_op(0, 2'd3, 32'h0000_0030, 1'b0, 1'b0, 0);
    n_cmp++;
    if (csr0 !== 32'h0000_00CF) begin
      n_fail++; $display("FAIL set_clear_result: got %h want 000000cf", csr0);
    end
    run_op(0, 2'd2, 32'h0, 1'b0, 1'b0, 0);
    run_op(0, 2'd3, 32'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_write_mask();
    load_csr(1, 32'hAAAA_0000);
    run_op(1, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    n_cmp++;
    if (csr1 !== 32'hAAAA_FFFF) begin
      n_fail++; $display("FAIL mask_result: got %h want aaaaffff", csr1);
    end
    run_op(1, 2'd3, 32'hFFFF_00FF, 1'b0, 1'b0, 0);
  endtask

  task automatic test_errors();
    load_csr(0, 32'h5555_0000);
    run_op(0, 2'd1, 32'h0000_1111, 1'b1, 1'b0, 0);
    run_op(0, 2'd1, 32'h0000_2222, 1'b0, 1'b1, 0);
    run_op(0, 2'd0, 32'h0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_hold();
    run_op(0, 2'd2, 32'h8000_0001, 1'b0, 1'b0, 5);
    run_op(1, 2'd1, 32'h0000_BEEF, 1'b0, 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    run_op(0, 2'd1, 32'hCAFE_F00D, 1'b0, 1'b0, 0);
    run_op(0, 2'd0, 32'h0, 1'b0, 1'b0, 0);
    run_op(0, 2'd3, 32'h0000_F00D, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int sel;
      logic [31:0] wd;
      sel = $urandom_range(0, 1);
      wd = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      run_op(sel, 2'($urandom_range(0, 3)), wd, ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_midop();
    bool_seen: begin
      bit seen;
      load_csr(0, 32'h0F0F_0F0F);
      req_valid[0] = 1'b1; req_op[0] = 2'd1; req_wdata[0] = 32'h7777_7777;
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (wr_en[0] !== 1'b1) begin
        n_fail++; $display("FAIL midop_in_write: got we=%b want 1", wr_en[0]);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || busy[0] !== 1'b0 || wr_en[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_reset: got v=%b rdy=%b busy=%b we=%b want 0,1,0,0",
                 rsp_valid[0], req_ready[0], busy[0], wr_en[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
        n_fail++; $display("FAIL midop_no_rsp: got spurious activity, want idle");
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_op[s] = 2'd0; req_wdata[s] = 32'd0; rsp_ready[s] = 1'b0;
      rd_err[s] = 1'b0; flip[s] = 32'd0; ld[s] = 1'b0; ld_val[s] = 32'd0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_read();
    test_write_verify();
    test_set_clear();
    test_write_mask();
    test_errors();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_midop();
    run_op(0, 2'd1, 32'h0000_0042, 1'b0, 1'b0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vcve2_csr_rmw_ctrl.md
Name: vcve2_csr_rmw_ctrl

Overview:
Sequencer that drives one CSR storage primitive (write-enable/write-data in; read-data and shadow-mismatch error out) as its access initiator. It accepts CSR operations (read, write, set-bits, clear-bits) over a valid/ready request channel. For each operation it reads the old value, computes the new value, and issues a single-cycle write. It can optionally read back to verify the write, then returns the old value and an error flag over a valid/ready response channel. It sits between the CSR-instruction decode path and the CSR primitives.

Parameters:
Width, 32, data width of CSR and request/response data
VerifyWrite, 1'b1, when 1 add a readback/compare cycle after every write
WriteMask, all ones (Width bits), bits set are software-writable; masked-off bits keep their old value

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid&ready
req_op_i  input  2  00 READ, 01 WRITE, 10 SET, 11 CLEAR
req_wdata_i  input  Width  operand
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid&ready
rsp_rdata_o  output  Width  CSR value before the operation
rsp_error_o  output  1  read-side shadow error or verify mismatch
csr_wr_en_o  output  1  write strobe to the CSR primitive
csr_wr_data_o  output  Width  write data to the CSR primitive
csr_rd_data_i  input  Width  current CSR value (combinational from primitive)
csr_rd_error_i  input  1  shadow mismatch from primitive
busy_o  output  1  state != IDLE

Behaviour:
- Reset is asynchronous, active-low; clock is clk_i. Reset forces state IDLE.
  - All registered outputs reset to 0: rsp_valid_o, rsp_rdata_o, rsp_error_o, csr_wr_en_o, csr_wr_data_o, busy_o.
  - req_ready_o is 1 after reset.
- FSM states: IDLE, READ, WRITE, VERIFY, RESP. req_ready_o = (state==IDLE). One request is in flight at a time.
- IDLE: on req_valid_i&req_ready_o, capture op_q and wdata_q, then go to READ.
- READ (1 cycle):
  - old_q <= csr_rd_data_i; err_q <= csr_rd_error_i.
  - raw = WRITE: wdata_q; SET: old|wdata_q; CLEAR: old&~wdata_q.
  - new_q <= (old & ~WriteMask) | (raw & WriteMask).
  - Go to RESP if op==READ, or if csr_rd_error_i=1 (no write on corrupted state), or if op is SET/CLEAR with wdata_q==0 (no write side effect). Otherwise go to WRITE.
- WRITE (1 cycle): csr_wr_en_o=1, csr_wr_data_o=new_q. Go to VERIFY if VerifyWrite, else RESP.
  - A WRITE whose value equals the old value is still written.
- VERIFY (1 cycle): err_q <= (csr_rd_data_i != new_q) | csr_rd_error_i. Go to RESP.
- RESP: rsp_valid_o=1, rsp_rdata_o=old_q, rsp_error_o=err_q.
  - All three are held stable while rsp_ready_i=0.
  - On rsp_ready_i=1, go to IDLE. The next request can be accepted the cycle after the handshake; RESP and IDLE are never combined.
- csr_wr_en_o is 1 only in WRITE, exactly one cycle per write; csr_wr_data_o holds new_q otherwise (don't-care when en=0).
- Latency, with the accept edge at cycle T:
  - READ, skipped write, or read error: READ at T+1, rsp_valid at T+2.
  - Write with VerifyWrite=1: WRITE at T+2, VERIFY at T+3, rsp_valid at T+4.
  - Write with VerifyWrite=0: rsp_valid at T+3.
- req_* inputs are ignored outside IDLE.
- Reset mid-operation: return to IDLE immediately; no response is issued. A write already strobed stays committed in the CSR.
- Assertions: req_valid_i and rsp_ready_i known; csr_wr_en_o implies state==WRITE; rsp_valid_o stays high until handshake.

Test Plan:
- CSR=0x0000_00A5, op READ → rsp at T+2, rdata=0xA5, error=0, csr_wr_en_o never asserted.
- CSR=0xA5, WRITE 0x1234_5678, VerifyWrite=1 → one wr_en pulse at T+2 with data 0x12345678; rsp at T+4 with rdata=0xA5, error=0; CSR now reads 0x12345678.
- CSR=0xF0, SET 0x0F then CLEAR 0x30 → CSR becomes 0xFF, then 0xCF; rdata 0xF0, then 0xFF. SET with 0x0 → no wr_en, rsp at T+2.
- WriteMask=0x0000_FFFF, CSR=0xAAAA_0000, WRITE 0xFFFF_FFFF → CSR=0xAAAA_FFFF, error=0.
- Force csr_rd_error_i=1 during READ → no write, rsp error=1. Force rd_data mismatch in VERIFY → error=1, rdata = old value.
- Hold rsp_ready_i=0 for 5 cycles → outputs stable, req_ready_o=0 throughout. Back-to-back requests → second accepted the cycle after the response handshake. Assert rst_ni during WRITE → IDLE, no rsp_valid, req_ready_o=1.
